// File: rtl/mux2x32_rr_arbiter.sv
// Two-source valid/ready arbiter feeding a single-entry registered output stage.
// Round-robin or fixed-priority grant, with saturating per-source beat counters.
module mux2x32_rr_arbiter #(
  parameter int WIDTH   = 32,
  parameter bit FAIR    = 1'b1,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   a0_data,
  input  logic               a0_valid,
  output logic               a0_ready,
  input  logic [WIDTH-1:0]   a1_data,
  input  logic               a1_valid,
  output logic               a1_ready,
  output logic [WIDTH-1:0]   y_data,
  output logic               y_valid,
  input  logic               y_ready,
  output logic               selection,
  output logic [COUNT_W-1:0] cnt0,
  output logic [COUNT_W-1:0] cnt1
);

  logic load_en;
  logic grant;
  logic accept;
  logic last_p0;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (&c) ? c : c + COUNT_W'(1);
  endfunction

  always_comb begin
    load_en = ~y_valid | y_ready;
    if (a0_valid && a1_valid)
      grant = FAIR ? ~last_p0 : 1'b0;
    else
      grant = a1_valid;
    // Readies are forced low while reset is being sampled.
    a0_ready = reset_n & load_en & a0_valid & ~grant;
    a1_ready = reset_n & load_en & a1_valid & grant;
    accept   = a0_ready | a1_ready;
  end

  // Output stage: capture the granted word, or drain when nothing is offered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      y_valid   <= 1'b0;
      y_data    <= '0;
      selection <= 1'b0;
      last_p0   <= 1'b1;
      cnt0      <= '0;
      cnt1      <= '0;
    end else if (load_en) begin
      if (accept) begin
        y_data    <= grant ? a1_data : a0_data;
        selection <= grant;
        y_valid   <= 1'b1;
        last_p0   <= grant;
        if (grant) cnt1 <= sat_inc(cnt1);
        else       cnt0 <= sat_inc(cnt0);
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux2x32_rr_arbiter.sv
// Directed bench for mux2x32_rr_arbiter: round-robin, fixed-priority and
// narrow-counter instances share one stimulus set.
module tb_mux2x32_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] a0_data, a1_data;
  logic        a0_valid, a1_valid, y_ready;

  logic [31:0] rr_y, fp_y, st_y;
  logic        rr_v, fp_v, st_v;
  logic        rr_s, fp_s, st_s;
  logic        rr_r0, rr_r1, fp_r0, fp_r1, st_r0, st_r1;
  logic [15:0] rr_c0, rr_c1, fp_c0, fp_c1;
  logic [1:0]  st_c0, st_c1;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  mux2x32_rr_arbiter #(.WIDTH(32), .FAIR(1'b1), .COUNT_W(16)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .a0_data(a0_data), .a0_valid(a0_valid), .a0_ready(rr_r0),
    .a1_data(a1_data), .a1_valid(a1_valid), .a1_ready(rr_r1),
    .y_data(rr_y), .y_valid(rr_v), .y_ready(y_ready),
    .selection(rr_s), .cnt0(rr_c0), .cnt1(rr_c1)
  );

  mux2x32_rr_arbiter #(.WIDTH(32), .FAIR(1'b0), .COUNT_W(16)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .a0_data(a0_data), .a0_valid(a0_valid), .a0_ready(fp_r0),
    .a1_data(a1_data), .a1_valid(a1_valid), .a1_ready(fp_r1),
    .y_data(fp_y), .y_valid(fp_v), .y_ready(y_ready),
    .selection(fp_s), .cnt0(fp_c0), .cnt1(fp_c1)
  );

  mux2x32_rr_arbiter #(.WIDTH(32), .FAIR(1'b1), .COUNT_W(2)) u_st (
    .clk(clk), .reset_n(reset_n),
    .a0_data(a0_data), .a0_valid(a0_valid), .a0_ready(st_r0),
    .a1_data(a1_data), .a1_valid(a1_valid), .a1_ready(st_r1),
    .y_data(st_y), .y_valid(st_v), .y_ready(y_ready),
    .selection(st_s), .cnt0(st_c0), .cnt1(st_c1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; a0_valid = 1'b0; a1_valid = 1'b0; y_ready = 1'b1;
    a0_data = '0; a1_data = '0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; a0_valid = 1'b1; a1_valid = 1'b1; y_ready = 1'b1;
    a0_data = 32'h5555_5555; a1_data = 32'hAAAA_AAAA;
    #1;
    total++;
    if ({rr_r0, rr_r1, fp_r0, fp_r1} !== 4'b0000)
      $display("FAIL reset_ready got=%b exp=0000", {rr_r0, rr_r1, fp_r0, fp_r1});
    else pass_cnt++;
    tick();
    reset_n = 1'b1; a0_valid = 1'b0; a1_valid = 1'b0;
    tick();
    total++;
    if ({rr_v, rr_s, rr_c0, rr_c1} !== 34'd0 || rr_y !== 32'd0)
      $display("FAIL reset_state got v=%b s=%b y=%h c0=%0d c1=%0d exp all 0",
               rr_v, rr_s, rr_y, rr_c0, rr_c1);
    else pass_cnt++;
    total++;
    if ({rr_r0, rr_r1} !== 2'b00)
      $display("FAIL reset_idle_ready got=%b exp=00", {rr_r0, rr_r1});
    else pass_cnt++;
  endtask

  task automatic test_single();
    apply_reset();
    a0_valid = 1'b1; a0_data = 32'hDEAD_BEEF; y_ready = 1'b1;
    #1;
    total++;
    if ({rr_r0, rr_r1} !== 2'b10)
      $display("FAIL single_ready got=%b exp=10", {rr_r0, rr_r1});
    else pass_cnt++;
    tick();
    a0_valid = 1'b0;
    total++;
    if (rr_v !== 1'b1 || rr_y !== 32'hDEAD_BEEF || rr_s !== 1'b0 || rr_c0 !== 16'd1)
      $display("FAIL single_beat got v=%b y=%h s=%b c0=%0d exp v=1 y=deadbeef s=0 c0=1",
               rr_v, rr_y, rr_s, rr_c0);
    else pass_cnt++;
    tick();
    total++;
    if (rr_v !== 1'b0 || rr_y !== 32'hDEAD_BEEF || rr_s !== 1'b0)
      $display("FAIL single_drain got v=%b y=%h s=%b exp v=0 y=deadbeef s=0",
               rr_v, rr_y, rr_s);
    else pass_cnt++;
  endtask

  task automatic test_fair_and_fixed();
    logic [31:0] exp_rr [6];
    logic        exp_sel[6];
    int          fp_r1_seen;
    exp_rr  = '{32'hA, 32'hB, 32'hA, 32'hB, 32'hA, 32'hB};
    exp_sel = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    fp_r1_seen = 0;
    apply_reset();
    a0_data = 32'h0000_000A; a1_data = 32'h0000_000B;
    a0_valid = 1'b1; a1_valid = 1'b1; y_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (fp_r1 !== 1'b0) fp_r1_seen++;
      tick();
      total++;
      if (rr_y !== exp_rr[i] || rr_s !== exp_sel[i] || rr_v !== 1'b1)
        $display("FAIL fair_beat%0d got y=%h s=%b v=%b exp y=%h s=%b v=1",
                 i, rr_y, rr_s, rr_v, exp_rr[i], exp_sel[i]);
      else pass_cnt++;
      total++;
      if (fp_y !== 32'hA || fp_s !== 1'b0)
        $display("FAIL fixed_beat%0d got y=%h s=%b exp y=0000000a s=0", i, fp_y, fp_s);
      else pass_cnt++;
    end
    a0_valid = 1'b0; a1_valid = 1'b0;
    total++;
    if (rr_c0 !== 16'd3 || rr_c1 !== 16'd3)
      $display("FAIL fair_counts got c0=%0d c1=%0d exp 3 3", rr_c0, rr_c1);
    else pass_cnt++;
    total++;
    if (fp_c0 !== 16'd6 || fp_c1 !== 16'd0 || fp_r1_seen != 0)
      $display("FAIL fixed_counts got c0=%0d c1=%0d a1_ready_hits=%0d exp 6 0 0",
               fp_c0, fp_c1, fp_r1_seen);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    apply_reset();
    a0_valid = 1'b1; a0_data = 32'h1234_5678; y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    a0_data = 32'h1111_1111; a1_data = 32'h2222_2222; a1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({rr_r0, rr_r1} !== 2'b00)
        $display("FAIL stall_ready%0d got=%b exp=00", i, {rr_r0, rr_r1});
      else pass_cnt++;
      tick();
      total++;
      if (rr_y !== 32'h1234_5678 || rr_s !== 1'b0 || rr_v !== 1'b1)
        $display("FAIL stall_hold%0d got y=%h s=%b v=%b exp y=12345678 s=0 v=1",
                 i, rr_y, rr_s, rr_v);
      else pass_cnt++;
    end
    y_ready = 1'b1;
    #1;
    total++;
    if ({rr_r0, rr_r1} !== 2'b01)
      $display("FAIL stall_release_ready got=%b exp=01", {rr_r0, rr_r1});
    else pass_cnt++;
    tick();
    a0_valid = 1'b0; a1_valid = 1'b0;
    total++;
    if (rr_y !== 32'h2222_2222 || rr_s !== 1'b1 || rr_v !== 1'b1 ||
        rr_c0 !== 16'd1 || rr_c1 !== 16'd1)
      $display("FAIL stall_next got y=%h s=%b v=%b c0=%0d c1=%0d exp y=22222222 s=1 v=1 c0=1 c1=1",
               rr_y, rr_s, rr_v, rr_c0, rr_c1);
    else pass_cnt++;
  endtask

  task automatic test_saturation_and_midreset();
    logic [1:0] exp_c[5];
    exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    apply_reset();
    a0_valid = 1'b1; a0_data = 32'hC0FF_EE00; y_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (st_c0 !== exp_c[i])
        $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, st_c0, exp_c[i]);
      else pass_cnt++;
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({st_r0, st_r1} !== 2'b00)
      $display("FAIL midreset_ready got=%b exp=00", {st_r0, st_r1});
    else pass_cnt++;
    tick();
    total++;
    if (st_v !== 1'b0 || st_c0 !== 2'd0 || st_y !== 32'd0 || rr_c0 !== 16'd0)
      $display("FAIL midreset_state got v=%b c0=%0d y=%h rr_c0=%0d exp v=0 c0=0 y=0 rr_c0=0",
               st_v, st_c0, st_y, rr_c0);
    else pass_cnt++;
    reset_n = 1'b1; a0_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; a0_valid = 1'b0; a1_valid = 1'b0; y_ready = 1'b0;
    a0_data = '0; a1_data = '0;
    test_reset();
    test_single();
    test_fair_and_fixed();
    test_stall();
    test_saturation_and_midreset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
